matmul_mac_sequencer: RTL

- Controller that computes a 2x2 unsigned matrix product C = A x B by sequencing a single shared external DATA_W x DATA_W multiplier.
- It issues 8 multiplies, routes each product to one of 4 accumulators, and publishes the 4 results with a done pulse.
- It is the area-reduced alternative to a fully parallel 2x2 multiplier: one multiplier instead of eight, and it accepts the same packed operand words the number loader consumes.

---
 rtl/matmul_mac_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/matmul_mac_sequencer.sv
// 2x2 unsigned matrix product C = A x B computed by time-sharing one external
// DATA_W x DATA_W multiplier: 8 issues, 4 accumulators, one done pulse.
module matmul_mac_sequencer #(
  parameter int DATA_W  = 8,
  parameter int MUL_LAT = 1,
  parameter int RES_W   = 2*DATA_W+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DATA_W-1:0]   nums_a,
  input  logic [4*DATA_W-1:0]   nums_b,
  output logic                  ready,
  output logic                  busy,
  output logic                  mul_valid,
  output logic [DATA_W-1:0]     mul_op_a,
  output logic [DATA_W-1:0]     mul_op_b,
  input  logic [2*DATA_W-1:0]   mul_p,
  output logic [RES_W-1:0]      result1,
  output logic [RES_W-1:0]      result2,
  output logic [RES_W-1:0]      result3,
  output logic [RES_W-1:0]      result4,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Stages 0..MUL_LAT-2 of the tag pipeline; the last stage is the one being absorbed.
  localparam logic [MUL_LAT-1:0] INNER_MASK = {MUL_LAT{1'b1}} >> 1;

  state_t                state;
  logic [4*DATA_W-1:0]   a_q;
  logic [4*DATA_W-1:0]   b_q;
  logic [2:0]            k;
  logic [MUL_LAT-1:0]    tag_vld;
  logic [2:0]            tag_pipe [MUL_LAT];
  logic [RES_W-1:0]      acc      [4];
  logic [RES_W-1:0]      acc_next [4];
  logic [2:0]            k_inc;
  logic [1:0]            out_e;

  // Element idx of a packed matrix word: 0=x11, 1=x12, 2=x21, 3=x22.
  function automatic logic [DATA_W-1:0] elem(input logic [4*DATA_W-1:0] m,
                                             input logic [1:0] idx);
    logic [DATA_W-1:0] v;
    case (idx)
      2'd0:    v = m[4*DATA_W-1:3*DATA_W];
      2'd1:    v = m[3*DATA_W-1:2*DATA_W];
      2'd2:    v = m[2*DATA_W-1:DATA_W];
      default: v = m[DATA_W-1:0];
    endcase
    return v;
  endfunction

  // Issue k multiplies A[k2][k0] by B[k0][k1] into element e = k[2:1].
  function automatic logic [DATA_W-1:0] op_a_of(input logic [4*DATA_W-1:0] m,
                                                input logic [2:0] kk);
    return elem(m, {kk[2], kk[0]});
  endfunction

  function automatic logic [DATA_W-1:0] op_b_of(input logic [4*DATA_W-1:0] m,
                                                input logic [2:0] kk);
    return elem(m, {kk[0], kk[1]});
  endfunction

  assign busy  = ~ready;
  assign k_inc = k + 3'd1;
  assign out_e = tag_pipe[MUL_LAT-1][2:1];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) acc_next[i] = acc[i];
    if (tag_vld[MUL_LAT-1]) begin
      if (tag_pipe[MUL_LAT-1][0])
        acc_next[out_e] = acc[out_e] + RES_W'(mul_p);
      else
        acc_next[out_e] = RES_W'(mul_p);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      mul_valid <= 1'b0;
      mul_op_a  <= '0;
      mul_op_b  <= '0;
      result1   <= '0;
      result2   <= '0;
      result3   <= '0;
      result4   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      k         <= '0;
      tag_vld   <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      // The tag travels alongside the operands so it meets its product MUL_LAT cycles later.
      tag_vld[0]  <= mul_valid;
      tag_pipe[0] <= k;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      for (int unsigned i = 0; i < 4; i++) acc[i] <= acc_next[i];
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= nums_a;
            b_q       <= nums_b;
            for (int unsigned i = 0; i < 4; i++) acc[i] <= '0;
            k         <= '0;
            mul_valid <= 1'b1;
            mul_op_a  <= op_a_of(nums_a, 3'd0);
            mul_op_b  <= op_b_of(nums_b, 3'd0);
            ready     <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (k == 3'd7) begin
            mul_valid <= 1'b0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
            state     <= DRAIN;
          end else begin
            k         <= k_inc;
            mul_op_a  <= op_a_of(a_q, k_inc);
            mul_op_b  <= op_b_of(b_q, k_inc);
          end
        end
        DRAIN: begin
          // Leave when only the final product remains; publish it via the bypassed sum.
          if (~|(tag_vld & INNER_MASK)) begin
            result1 <= acc_next[0];
            result2 <= acc_next[1];
            result3 <= acc_next[2];
            result4 <= acc_next[3];
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
